// File: rtl/xor_parity_acc_if.sv
// Frame-beat input and parity-result output bundle for xor_parity_acc.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface xor_parity_acc_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             odd_mode;
  logic             chk_en;
  logic             chk_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic             out_err;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, odd_mode, chk_en, chk_bit, out_ready,
    output in_ready, out_valid, out_parity, out_err, out_count
  );

  modport master (
    output in_valid, in_data, in_last, odd_mode, chk_en, chk_bit, out_ready,
    input  in_ready, out_valid, out_parity, out_err, out_count
  );
endinterface

// File: rtl/xor_parity_acc.sv
// Accumulates the XOR parity of a beat frame and presents parity, check error
// and saturating beat count as one held result per frame.
module xor_parity_acc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  xor_parity_acc_if.slave      bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_acc;
  logic             r_odd;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic             r_out_parity;
  logic             r_out_err;
  logic [CNT_W-1:0] r_out_count;

  logic [WIDTH-1:0] w_data;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_first;
  logic             w_beat_par;
  logic             w_acc_next;
  logic             w_odd_sel;
  logic             w_par_final;
  logic [CNT_W-1:0] w_cnt_next;

  // in_ready is decoded straight from state so it drops the instant rst rises
  assign w_in_ready  = !rst && (r_state != HOLD);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_first     = (r_state == IDLE);
  assign w_data      = bus.in_data;
  assign w_beat_par  = ^w_data;
  assign w_acc_next  = w_first ? w_beat_par : (r_acc ^ w_beat_par);
  assign w_odd_sel   = w_first ? bus.odd_mode : r_odd;
  assign w_par_final = w_acc_next ^ w_odd_sel;
  assign w_cnt_next  = w_first                ? CNT_W'(1) :
                       (r_count == CNT_MAX)   ? r_count   :
                                                r_count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_acc        <= 1'b0;
      r_odd        <= 1'b0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_out_parity <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_count  <= '0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          if (w_accept) begin
            r_acc   <= w_acc_next;
            r_count <= w_cnt_next;
            if (w_first) begin
              r_odd <= bus.odd_mode;
            end
            if (bus.in_last) begin
              r_state      <= HOLD;
              r_out_valid  <= 1'b1;
              r_out_parity <= w_par_final;
              r_out_err    <= bus.chk_en && (bus.chk_bit != w_par_final);
              r_out_count  <= w_cnt_next;
            end else begin
              r_state <= ACC;
            end
          end
        end
        HOLD: begin
          // result stays frozen until the consumer takes it
          if (r_out_valid && bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_parity = r_out_parity;
  assign bus.out_err    = r_out_err;
  assign bus.out_count  = r_out_count;

endmodule

// File: tb/tb_xor_parity_acc.sv
// Self-checking bench for xor_parity_acc: vector table plus backpressure,
// reset and saturation sequences, with a result scoreboard.
module tb_xor_parity_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xor_parity_acc_if #(.WIDTH(8), .CNT_W(8)) bus ();
  xor_parity_acc_if #(.WIDTH(8), .CNT_W(4)) bus4 ();

  xor_parity_acc #(.WIDTH(8), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  xor_parity_acc #(.WIDTH(8), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       par;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    int unsigned n;
    logic [7:0]  d [4];
    logic        odd;
    logic        en;
    logic        cb;
    logic        par;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  exp_t sb [$];
  exp_t mon_e;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare each handshaken result against the oldest pushed frame
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got result cnt=%0d with empty queue at %0t", bus.out_count, $time);
      end else begin
        mon_e = sb.pop_front();
        check("mon_parity", 32'(bus.out_parity), 32'(mon_e.par));
        check("mon_err",    32'(bus.out_err),    32'(mon_e.err));
        check("mon_count",  32'(bus.out_count),  32'(mon_e.cnt));
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic last, input logic odd,
                           input logic en, input logic cb);
    bit ok = 1'b0;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.odd_mode = odd;
    bus.chk_en   = en;
    bus.chk_bit  = cb;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 at %0t", $time);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (last) begin
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
    end
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    e.par = v.par;
    e.err = v.err;
    e.cnt = v.cnt;
    sb.push_back(e);
    for (int unsigned i = 0; i < v.n; i++) begin
      send_beat(v.d[i], (i == v.n - 1), v.odd, v.en, v.cb);
    end
  endtask

  task automatic push_exp(input logic par, input logic err, input logic [7:0] cnt);
    exp_t e;
    e.par = par;
    e.err = err;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    // {beats, data, odd, chk_en, chk_bit, exp parity, exp err, exp count}
    vecs[0] = '{1, '{8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[1] = '{3, '{8'h01, 8'h03, 8'h07, 8'h00}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3};
    vecs[2] = '{1, '{8'h80, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[3] = '{2, '{8'hFF, 8'h0F, 8'h00, 8'h00}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[4] = '{4, '{8'h01, 8'h02, 8'h04, 8'h08}, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4};
    vecs[5] = '{2, '{8'h7F, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[6] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};

    rst = 1'b1;
    bus.in_valid  = 1'b0;  bus.in_data  = 8'h00; bus.in_last  = 1'b0;
    bus.odd_mode  = 1'b0;  bus.chk_en   = 1'b0;  bus.chk_bit  = 1'b0;
    bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0;  bus4.in_data = 8'h00; bus4.in_last = 1'b0;
    bus4.odd_mode = 1'b0;  bus4.chk_en  = 1'b0;  bus4.chk_bit = 1'b0;
    bus4.out_ready = 1'b1;

    #12;
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_in_ready",   32'(bus.in_ready),   32'd0);
    check("rst_out_count",  32'(bus.out_count),  32'd0);
    check("rst_out_parity", 32'(bus.out_parity), 32'd0);
    check("rst_out_err",    32'(bus.out_err),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i]);
    end

    // odd_mode latched on first beat, chk_en/chk_bit taken from last beat
    push_exp(1'b0, 1'b0, 8'd2);
    send_beat(8'h03, 1'b0, 1'b1, 1'b1, 1'b1);
    send_beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // backpressure: result held, producer beats ignored
    bus.out_ready = 1'b0;
    push_exp(1'b0, 1'b0, 8'd1);
    send_beat(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_last  = 1'b1;
    bus.chk_en   = 1'b1;
    bus.chk_bit  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid",    32'(bus.out_valid),  32'd1);
      check("hold_ready0",   32'(bus.in_ready),   32'd0);
      check("hold_count",    32'(bus.out_count),  32'd1);
      check("hold_parity",   32'(bus.out_parity), 32'd0);
      check("hold_err",      32'(bus.out_err),    32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_ready", 32'(bus.in_ready),  32'd1);
    check("keep_count",    32'(bus.out_count), 32'd1);

    // reset in mid-frame discards the partial frame
    send_beat(8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    send_beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid",  32'(bus.out_valid),  32'd0);
    check("mid_rst_ready",  32'(bus.in_ready),   32'd0);
    check("mid_rst_count",  32'(bus.out_count),  32'd0);
    check("mid_rst_parity", 32'(bus.out_parity), 32'd0);
    check("mid_rst_err",    32'(bus.out_err),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(1'b0, 1'b0, 8'd1);
    send_beat(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // CNT_W=4 instance: 20 beats saturate the count at 15
    bus4.in_valid = 1'b1;
    bus4.in_data  = 8'h01;
    for (int b = 0; b < 20; b++) begin
      bus4.in_last = (b == 19);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus4.in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        n_checks++;
        n_err++;
        $display("FAIL sat_accept_timeout: in_ready stayed 0, required 1 at beat %0d", b);
        break;
      end
      @(posedge clk);
      #1;
    end
    bus4.in_valid = 1'b0;
    check("sat_valid",  32'(bus4.out_valid),  32'd1);
    check("sat_count",  32'(bus4.out_count),  32'd15);
    check("sat_parity", 32'(bus4.out_parity), 32'd0);
    check("sat_err",    32'(bus4.out_err),    32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
